// File: rtl/imem_loader_pkg.sv
// loader_pkg: shared widths, byte-assembly constants and FSM state type for imem_loader
package loader_pkg;
   localparam int DEFAULT_ADDR_W = 19;
   localparam int BYTES_PER_WORD = 4;
   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
   typedef enum logic [2:0] {LEN, DATA, CSUM, DONE, ERR} loader_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: UART byte input, instruction-memory write port and load status
interface imem_loader_if import loader_pkg::*; #(parameter int ADDR_W = DEFAULT_ADDR_W);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              loading;
   logic              load_done;
   logic              load_error;
   logic              fetch_start;
   modport master (input rx_valid, rx_data,
                   output imem_we, imem_addr, imem_wdata, loading, load_done, load_error, fetch_start);
   modport slave (output rx_valid, rx_data,
                  input imem_we, imem_addr, imem_wdata, loading, load_done, load_error, fetch_start);
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: packs a big-endian byte stream into 32-bit words, flagging the 4th byte
module byte_assembler import loader_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [7:0]  data,
   output logic        word_valid,
   output logic [31:0] word
);
   logic [1:0]  cnt_q;
   logic [23:0] sh_q;
   assign word_valid = valid && cnt_q == LAST_BYTE;
   assign word = {sh_q, data};
   // shift in each accepted byte; the counter wraps naturally every four bytes
   always_ff @(posedge clk)
      if (rst) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else if (valid) begin
         cnt_q <= cnt_q + 2'd1;
         sh_q  <= {sh_q[15:0], data};
      end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed word stream into instruction memory, then pulses fetch_start
// Optional trailer checksum is compiled in with IMEM_LOADER_CHECKSUM_EN.
module imem_loader import loader_pkg::*; #(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DEPTH  = 2**ADDR_W
) (
   input logic clk,
   input logic rst,
   imem_loader_if.master bus
);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam loader_state_t FIN = CSUM;
   logic [31:0] acc_q, acc_d;
`else
   localparam loader_state_t FIN = DONE;
`endif
   loader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, addr_q, addr_d;
   logic [31:0]       wcnt_q, wcnt_d, len_q, len_d, wdata_q, wdata_d, word;
   logic              we_q, we_d, loading_q, loading_d, fetch_q, fetch_d, rx_in, word_valid;
   assign rx_in = bus.rx_valid && state_q inside {LEN, DATA, CSUM};
   byte_assembler u_asm (
      .clk(clk), .rst(rst), .valid(rx_in), .data(bus.rx_data),
      .word_valid(word_valid), .word(word)
   );
   // register FSM state, counters and all outputs
   always_ff @(posedge clk)
      if (rst) begin
         state_q   <= LEN;
         wr_addr_q <= '0;
         wcnt_q    <= '0;
         len_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         loading_q <= 1'b0;
         fetch_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         acc_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         wcnt_q    <= wcnt_d;
         len_q     <= len_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         loading_q <= loading_d;
         fetch_q   <= fetch_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         acc_q     <= acc_d;
`endif
      end
   // next state: length field, data words (one write per word), optional checksum trailer
   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      wcnt_d    = wcnt_q;
      len_d     = len_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_d     = acc_q;
`endif
      unique case (state_q)
         LEN: if (word_valid) begin
            len_d   = word;
            state_d = word > 32'(DEPTH) ? ERR : word == '0 ? FIN : DATA;
         end
         DATA: if (word_valid) begin
            we_d      = 1'b1;
            addr_d    = wr_addr_q;
            wdata_d   = word;
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            wcnt_d    = wcnt_q + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_d     = acc_q + word;
`endif
            state_d   = wcnt_q + 32'd1 == len_q ? FIN : DATA;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: if (word_valid) state_d = word == acc_q ? DONE : ERR;
`endif
         default: ;
      endcase
      loading_d = !(state_d inside {DONE, ERR}) && (loading_q || rx_in);
      fetch_d   = state_d == DONE && state_q != DONE;
   end
   assign bus.imem_we     = we_q;
   assign bus.imem_addr   = addr_q;
   assign bus.imem_wdata  = wdata_q;
   assign bus.loading     = loading_q;
   assign bus.load_done   = state_q == DONE;
   assign bus.load_error  = state_q == ERR;
   assign bus.fetch_start = fetch_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; expected writes queued as words are sent
module tb_imem_loader;
   import loader_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   imem_loader_if #(.ADDR_W(19)) bus();
   imem_loader #(.ADDR_W(19), .DEPTH(2**19)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   int checks = 0, passes = 0, fs_cnt = 0, extra_we = 0, fs0, we0;
   logic [50:0] sb[$];
   logic [31:0] words[$];
   function automatic void check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endfunction
   // write monitor: pops the scoreboard on every write and counts fetch_start pulses
   always @(negedge clk) begin
      logic [50:0] e;
      if (bus.fetch_start) fs_cnt++;
      if (bus.imem_we) begin
         if (sb.size() == 0) extra_we++;
         else begin
            e = sb.pop_front();
            check("wr_addr", 64'(bus.imem_addr), 64'(e[50:32]));
            check("wr_data", 64'(bus.imem_wdata), 64'(e[31:0]));
         end
      end
   end
   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask
   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], maxgap == 0 ? 0 : int'($urandom_range(maxgap, 0)));
   endtask
   task automatic reset_dut;
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      fs0 = fs_cnt;
      we0 = extra_we;
   endtask
   task automatic send_load(input logic [31:0] ws[$], input int maxgap);
      logic [31:0] sum = '0;
      send_word(32'(ws.size()), maxgap);
      for (int i = 0; i < ws.size(); i++) begin
         sb.push_back({19'(i), ws[i]});
         sum += ws[i];
         send_word(ws[i], maxgap);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(sum, maxgap);
`endif
   endtask
   task automatic check_done(input string tag);
      check({tag, "_fetch_start"}, 64'(bus.fetch_start), 64'd1);
      check({tag, "_load_done"}, 64'(bus.load_done), 64'd1);
      check({tag, "_loading"}, 64'(bus.loading), 64'd0);
      check({tag, "_load_error"}, 64'(bus.load_error), 64'd0);
      @(negedge clk);
      check({tag, "_fs_pulse_end"}, 64'(bus.fetch_start), 64'd0);
      check({tag, "_fs_count"}, 64'(fs_cnt - fs0), 64'd1);
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
      check({tag, "_extra_we"}, 64'(extra_we - we0), 64'd0);
   endtask
   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;
      @(negedge clk);
      reset_dut();
      check("rst_we", 64'(bus.imem_we), 64'd0);
      check("rst_addr", 64'(bus.imem_addr), 64'd0);
      check("rst_wdata", 64'(bus.imem_wdata), 64'd0);
      check("rst_loading", 64'(bus.loading), 64'd0);
      check("rst_done", 64'(bus.load_done), 64'd0);
      check("rst_error", 64'(bus.load_error), 64'd0);
      check("rst_fetch", 64'(bus.fetch_start), 64'd0);
      // two words back-to-back
      words = '{32'hDEADBEEF, 32'h01234567};
      send_load(words, 0);
      check_done("n2");
      // empty program: first byte starts loading, done right after the length field
      reset_dut();
      send_byte(8'h00, 0);
      check("n0_loading_rise", 64'(bus.loading), 64'd1);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("n0_csum_wait", 64'(bus.load_done), 64'd0);
      send_word(32'h0, 0);
`endif
      check_done("n0");
      // length exactly DEPTH is accepted
      reset_dut();
      send_word(32'h00080000, 0);
      check("depth_error", 64'(bus.load_error), 64'd0);
      check("depth_loading", 64'(bus.loading), 64'd1);
      // overflow: error, no writes, trailing bytes ignored
      reset_dut();
      send_word(32'h00080001, 0);
      check("ovf_error", 64'(bus.load_error), 64'd1);
      check("ovf_loading", 64'(bus.loading), 64'd0);
      check("ovf_done", 64'(bus.load_done), 64'd0);
      send_word(32'hDEADBEEF, 0);
      send_word(32'h12345678, 0);
      repeat (3) @(negedge clk);
      check("ovf_error_hold", 64'(bus.load_error), 64'd1);
      check("ovf_extra_we", 64'(extra_we - we0), 64'd0);
      check("ovf_fs", 64'(fs_cnt - fs0), 64'd0);
      // reset after 6 of 8 data bytes, with a byte coincident with reset, then a fresh load
      reset_dut();
      send_word(32'd2, 0);
      sb.push_back({19'd0, 32'hDEADBEEF});
      send_word(32'hDEADBEEF, 0);
      send_byte(8'h01, 0);
      send_byte(8'h23, 0);
      rst = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'h45;
      @(negedge clk);
      rst = 1'b0;
      bus.rx_valid = 1'b0;
      check("mid_rst_loading", 64'(bus.loading), 64'd0);
      check("mid_rst_sb", 64'(sb.size()), 64'd0);
      fs0 = fs_cnt;
      words = '{32'hCAFEBABE};
      send_load(words, 0);
      check_done("mid_rst");
`ifdef IMEM_LOADER_CHECKSUM_EN
      // checksum wraps mod 2^32: 1 + FFFFFFFF = 0
      reset_dut();
      words = '{32'h00000001, 32'hFFFFFFFF};
      send_load(words, 0);
      check_done("csum_ok");
      reset_dut();
      send_word(32'd2, 0);
      sb.push_back({19'd0, 32'h00000001});
      sb.push_back({19'd1, 32'hFFFFFFFF});
      send_word(32'h00000001, 0);
      send_word(32'hFFFFFFFF, 0);
      send_word(32'h00000001, 0);
      check("csum_bad_error", 64'(bus.load_error), 64'd1);
      check("csum_bad_done", 64'(bus.load_done), 64'd0);
      repeat (2) @(negedge clk);
      check("csum_bad_fs", 64'(fs_cnt - fs0), 64'd0);
      check("csum_bad_sb", 64'(sb.size()), 64'd0);
`endif
      // random idle gaps between bytes, then extra bytes after completion
      reset_dut();
      words = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
      send_load(words, 5);
      repeat (8) @(negedge clk);
      check("gap_done", 64'(bus.load_done), 64'd1);
      send_word(32'hA5A5A5A5, 2);
      send_word(32'h00000003, 0);
      repeat (3) @(negedge clk);
      check("gap_done_hold", 64'(bus.load_done), 64'd1);
      check("gap_fs", 64'(fs_cnt - fs0), 64'd1);
      check("gap_sb", 64'(sb.size()), 64'd0);
      check("gap_extra_we", 64'(extra_we - we0), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
